// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data requester and memory port bundle.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_fill;
  logic [DATA_W-1:0] i_stream;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_fill;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_ack, mem_rdata,
    output i_fill, i_stream, i_done,
    output d_fill, d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_ack, mem_rdata,
    input  i_fill, i_stream, i_done,
    input  d_fill, d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of the 64-bit memory port
// between fetch refill and data access.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, GRANT, BUSY, DONE
  } state_e;

  localparam int LSB = $clog2(BEATS * 8);
  localparam logic [ADDR_W-1:0] AMASK =
    {ADDR_W{1'b1}} << LSB;
  localparam logic [3:0] LAST = 4'(BEATS - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pick;
  logic              busy;
  logic              fin;

  // owner encoding: 0 = fetch, 1 = data; ties go to
  // whoever was not served last
  assign pick = (bus.i_req & bus.d_req) ? ~last_q
                                        : bus.d_req;
  assign busy = state_q == BUSY;
  assign fin  = bus.mem_ack & (we_q | cnt_q == LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_req | bus.d_req) state_d = GRANT;
      GRANT:   state_d = BUSY;
      BUSY:    if (fin) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // owner, transaction capture and beat counting
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) owner_d = pick;
    if (state_q == GRANT) begin
      we_d    = owner_q & bus.d_we;
      addr_d  = (owner_q ? bus.d_addr : bus.i_addr) & AMASK;
      wdata_d = bus.d_wdata;
      cnt_d   = '0;
      last_d  = owner_q;
    end
    if (busy & bus.mem_ack) cnt_d = cnt_q + 4'd1;
  end

  // transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // port drive, fill steering and done pulses
  always_comb begin
    bus.mem_req   = busy;
    bus.mem_we    = busy & we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.i_fill    = busy & bus.mem_ack & ~owner_q & ~we_q;
    bus.d_fill    = busy & bus.mem_ack & owner_q & ~we_q;
    bus.i_stream  = bus.mem_rdata;
    bus.d_rdata   = bus.mem_rdata;
    bus.i_done    = (state_q == DONE) & ~owner_q;
    bus.d_done    = (state_q == DONE) & owner_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed literals plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int BEATS = 4;
  localparam int LINE  = BEATS * 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(64), .BEATS(BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: who holds the port and what it expects
  int          m_side  = -1;
  int          m_done  = -1;
  int          m_got   = 0;
  bit          m_open  = 0;
  bit          m_we    = 0;
  bit          m_lastd = 1;
  logic [31:0] m_addr  = '0;
  logic [63:0] m_wdata = '0;

  task automatic lit(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_side = -1; m_done = -1; m_open = 0;
      m_lastd = 1; m_got = 0;
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (m_side < 0) begin
      if (bus.i_req || bus.d_req) begin
        if (bus.i_req && bus.d_req) m_side = m_lastd ? 0 : 1;
        else m_side = bus.d_req ? 1 : 0;
      end
    end else if (!m_open) begin
      m_we    = (m_side == 1) && bus.d_we;
      m_addr  = m_side == 1 ? bus.d_addr : bus.i_addr;
      m_addr  = (m_addr / LINE) * LINE;
      m_wdata = bus.d_wdata;
      m_lastd = m_side == 1;
      m_open  = 1;
      m_got   = 0;
    end else if (bus.mem_ack) begin
      m_got++;
      if (m_we || m_got == BEATS) begin
        m_done = m_side;
        m_side = -1;
        m_open = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      lit("rst_mem_req", bus.mem_req, 0);
      lit("rst_mem_we", bus.mem_we, 0);
      lit("rst_mem_addr", bus.mem_addr, 0);
      lit("rst_mem_wdata", bus.mem_wdata, 0);
      lit("rst_i_fill", bus.i_fill, 0);
      lit("rst_d_fill", bus.d_fill, 0);
      lit("rst_i_done", bus.i_done, 0);
      lit("rst_d_done", bus.d_done, 0);
    end else begin
      lit("mem_req", bus.mem_req, m_open);
      if (m_open) begin
        lit("mem_addr", bus.mem_addr, m_addr);
        lit("mem_we", bus.mem_we, m_we);
        if (m_we) lit("mem_wdata", bus.mem_wdata, m_wdata);
      end
      lit("i_fill", bus.i_fill,
          m_open && bus.mem_ack && m_side == 0 && !m_we);
      lit("d_fill", bus.d_fill,
          m_open && bus.mem_ack && m_side == 1 && !m_we);
      lit("i_done", bus.i_done, m_done == 0);
      lit("d_done", bus.d_done, m_done == 1);
      lit("i_stream", bus.i_stream, bus.mem_rdata);
      lit("d_rdata", bus.d_rdata, bus.mem_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_req();
    bit ok;
    ok = 0;
    for (int k = 0; k < 12 && !ok; k++) begin
      cyc();
      smp();
      if (bus.mem_req) ok = 1;
    end
    lit("grant_timeout", ok, 1);
  endtask

  task automatic acks(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      bus.mem_ack = 1;
      bus.mem_rdata = {$urandom, $urandom};
      smp();
    end
  endtask

  initial begin
    int fills;
    rst_n = 0;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    repeat (2) cyc();
    rst_n = 1;

    cyc();
    bus.i_req = 1; bus.i_addr = 32'h0000_1234;
    smp();
    lit("lat_idle", bus.mem_req, 0);
    cyc(); smp();
    lit("lat_grant", bus.mem_req, 0);
    cyc();
    bus.mem_ack = 1;
    bus.mem_rdata = 64'hDEADBEEF_CAFEF00D;
    smp();
    lit("lat_busy", bus.mem_req, 1);
    lit("f_addr", bus.mem_addr, 32'h0000_1220);
    lit("f_fill", bus.i_fill, 1);
    lit("f_data", bus.i_stream, 64'hDEADBEEF_CAFEF00D);
    lit("f_dfill", bus.d_fill, 0);
    cyc(); bus.mem_ack = 0; smp();
    lit("f_wait_fill", bus.i_fill, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); bus.mem_ack = 1; smp();
      lit("f_done_early", bus.i_done, 0);
    end
    cyc(); bus.i_req = 0; smp();
    lit("f_done", bus.i_done, 1);
    lit("stray_done_fill", bus.i_fill, 0);
    lit("done_req", bus.mem_req, 0);
    cyc(); smp();
    lit("f_done_once", bus.i_done, 0);
    lit("stray_idle_fill", bus.i_fill, 0);

    cyc();
    bus.mem_ack = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100;
    bus.d_wdata = 64'h1122334455667788;
    smp();
    wait_req();
    lit("w_addr", bus.mem_addr, 32'h100);
    lit("w_we", bus.mem_we, 1);
    lit("w_data", bus.mem_wdata, 64'h1122334455667788);
    cyc();
    bus.d_wdata = 64'hFFFF_0000_FFFF_0000;
    bus.d_addr = 32'hABC; bus.mem_ack = 1;
    smp();
    lit("w_hold", bus.mem_wdata, 64'h1122334455667788);
    lit("w_fill", bus.d_fill, 0);
    cyc(); bus.mem_ack = 0; bus.d_req = 0; smp();
    lit("w_done", bus.d_done, 1);

    cyc();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    smp();
    wait_req();
    lit("b_addr", bus.mem_addr, 32'h40);
    lit("b_we", bus.mem_we, 0);
    fills = 0;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 2; w++) begin
        cyc(); bus.mem_ack = 0; smp();
        lit("b_wait_fill", bus.d_fill, 0);
      end
      cyc(); bus.mem_ack = 1; smp();
      fills += int'(bus.d_fill);
      lit("b_done_early", bus.d_done, 0);
    end
    lit("b_fills", fills, 4);
    cyc(); bus.mem_ack = 0; bus.d_req = 0; smp();
    lit("b_done", bus.d_done, 1);

    cyc(); bus.i_req = 1; bus.i_addr = 32'h3000; smp();
    wait_req();
    cyc(); rst_n = 0; bus.i_req = 0; bus.mem_ack = 1; smp();
    lit("r_req", bus.mem_req, 0);
    lit("r_fill", bus.i_fill, 0);
    cyc(); smp();
    lit("r_done", bus.i_done, 0);

    cyc();
    rst_n = 1; bus.mem_ack = 0;
    bus.i_req = 1; bus.i_addr = 32'h1000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000;
    smp();
    lit("r_no_done", bus.i_done, 0);
    wait_req();
    lit("rr_first", bus.mem_addr, 32'h1000);
    cyc(); bus.i_req = 0; bus.mem_ack = 1; smp();
    lit("drop_fill", bus.i_fill, 1);
    acks(3);
    cyc(); bus.mem_ack = 0; smp();
    lit("drop_done", bus.i_done, 1);
    wait_req();
    lit("rr_second", bus.mem_addr, 32'h2000);
    cyc(); bus.i_req = 1; smp();
    acks(4);
    cyc(); bus.mem_ack = 0; smp();
    lit("rr_d_done", bus.d_done, 1);
    wait_req();
    lit("rr_alt", bus.mem_addr, 32'h1000);

    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (bus.i_req) begin
        if (m_done == 0 && $urandom_range(1, 0) == 1)
          bus.i_req = 0;
      end else if ($urandom_range(2, 0) == 0) begin
        bus.i_req = 1;
      end
      if (bus.d_req) begin
        if (m_done == 1 && $urandom_range(1, 0) == 1)
          bus.d_req = 0;
      end else if ($urandom_range(2, 0) == 0) begin
        bus.d_req = 1;
      end
      bus.i_addr    = $urandom;
      bus.d_addr    = $urandom;
      bus.d_we      = 1'($urandom_range(1, 0));
      bus.d_wdata   = {$urandom, $urandom};
      bus.mem_ack   = $urandom_range(2, 0) == 0;
      bus.mem_rdata = {$urandom, $urandom};
    end
    smp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
